// File: rtl/card_anim_ctrl.sv
// Card-draw animation sequencer: slides one card sprite from the deck to a hand slot,
// one step per video frame. Optional dwell at the target is enabled by CARD_ANIM_HOLD_EN.
module card_anim_ctrl #(
  parameter int unsigned DECK_X      = 300,
  parameter int unsigned DECK_Y      = 200,
  parameter int unsigned HAND_X0     = 40,
  parameter int unsigned HAND_Y      = 400,
  parameter int unsigned HAND_PITCH  = 36,
  parameter int unsigned MAX_SLOTS   = 8,
  parameter int unsigned STEP        = 8,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       draw_req,
  input  logic [2:0] draw_slot,
  output logic       draw_ack,
  output logic       draw_err,
  output logic       draw_done,
  output logic       busy,
  output logic [9:0] x_pin,
  output logic [9:0] y_pin,
  output logic       sprite_en
);

  localparam int unsigned PW = 10;

  if (STEP < 1 || MAX_SLOTS < 1 || MAX_SLOTS > 8 || HOLD_FRAMES < 1) begin : g_param_chk
    $error("card_anim_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLIDE = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0] tx_q, tx_d, ty_q, ty_d;
  logic          arrived_q, arrived_d;
  logic          ack_q, ack_d, err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic          slot_ok_c;
  logic [PW-1:0] x_step_c, y_step_c;

`ifdef CARD_ANIM_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // One axis step: compare first so the unsigned subtraction never wraps.
  function automatic logic [PW-1:0] step_axis(input logic [PW-1:0] cur,
                                              input logic [PW-1:0] tgt);
    logic [PW-1:0] stp;
    logic [PW-1:0] res;
    stp = PW'(STEP);
    if (tgt >= cur) begin
      res = ((tgt - cur) <= stp) ? tgt : (cur + stp);
    end else begin
      res = ((cur - tgt) <= stp) ? tgt : (cur - stp);
    end
    return res;
  endfunction

  assign slot_ok_c = (32'(draw_slot) < MAX_SLOTS);
  assign x_step_c  = step_axis(x_q, tx_q);
  assign y_step_c  = step_axis(y_q, ty_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (draw_req && slot_ok_c) state_d = S_SLIDE;
`ifdef CARD_ANIM_HOLD_EN
      S_SLIDE: if (arrived_q) state_d = S_HOLD;
      S_HOLD:  if (frame_start && (hold_q == '0)) state_d = S_DONE;
`else
      S_SLIDE: if (arrived_q) state_d = S_DONE;
      S_HOLD:  state_d = S_IDLE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    arrived_d = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
`ifdef CARD_ANIM_HOLD_EN
    hold_d    = HW'(HOLD_FRAMES - 1);
`endif
    unique case (state_q)
      S_IDLE: begin
        if (draw_req) begin
          ack_d = 1'b1;
          if (slot_ok_c) begin
            tx_d = PW'(HAND_X0) + PW'(draw_slot) * PW'(HAND_PITCH);
            ty_d = PW'(HAND_Y);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SLIDE: begin
        if (frame_start) begin
          x_d       = x_step_c;
          y_d       = y_step_c;
          arrived_d = (x_step_c == tx_q) && (y_step_c == ty_q);
        end
      end
      S_HOLD: begin
`ifdef CARD_ANIM_HOLD_EN
        hold_d = hold_q;
        if (frame_start && (hold_q != '0)) hold_d = hold_q - HW'(1);
`endif
      end
      S_DONE: begin
        x_d = PW'(DECK_X);
        y_d = PW'(DECK_Y);
      end
      default: ;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= PW'(DECK_X);
      y_q       <= PW'(DECK_Y);
      tx_q      <= PW'(DECK_X);
      ty_q      <= PW'(DECK_Y);
      arrived_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      arrived_q <= arrived_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

`ifdef CARD_ANIM_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) hold_q <= HW'(HOLD_FRAMES - 1);
    else     hold_q <= hold_d;
  end
`endif

  assign draw_ack  = ack_q;
  assign draw_err  = err_q;
  assign draw_done = done_q;
  assign busy      = busy_q;
  assign sprite_en = busy_q;
  assign x_pin     = x_q;
  assign y_pin     = y_q;

endmodule

// File: doc/card_anim_ctrl.md
# card_anim_ctrl

Sequences the card-draw animation for the hand display. On a draw request from game logic, it moves one card sprite from the deck position to a hand slot, one step per video frame. It drives the `x_pin`/`y_pin` origin inputs of the 30×50 card sprite renderer and gates that renderer's output with `sprite_en`. Position registers change only on frame boundaries, so the sprite never tears mid-frame.

## Interface
- `DECK_X`, default 300: deck sprite origin x (pixels).
- `DECK_Y`, default 200: deck sprite origin y.
- `HAND_X0`, default 40: origin x of hand slot 0.
- `HAND_Y`, default 400: origin y of all hand slots.
- `HAND_PITCH`, default 36: x spacing between slots.
- `MAX_SLOTS`, default 8: number of valid slots, ≤ 8.
- `STEP`, default 8: maximum per-frame movement on each axis, in pixels, ≥ 1.
- `HOLD_FRAMES`, default 4: frames to dwell at the target before completing, ≥ 1.
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `draw_req` in 1: level request from game logic.
- `draw_slot` in 3: target slot index, sampled with `draw_req`.
- `draw_ack` out 1: one-cycle pulse when a request is accepted.
- `draw_err` out 1: one-cycle pulse when a request is rejected because `draw_slot` ≥ `MAX_SLOTS`.
- `draw_done` out 1: one-cycle pulse when the animation completes.
- `busy` out 1: high while not IDLE.
- `x_pin` out 10: sprite origin x, drives the renderer.
- `y_pin` out 10: sprite origin y, drives the renderer.
- `sprite_en` out 1: renderer output enable; the downstream mux forces black when low.

## Operation
- Reset values:
  - State IDLE.
  - `x_pin`=`DECK_X`, `y_pin`=`DECK_Y`.
  - All pulses 0; `busy`=0; `sprite_en`=0.
- State IDLE:
  - If `draw_req`=1 and `draw_slot` < `MAX_SLOTS`:
    - Latch `tx` = `HAND_X0` + `draw_slot`·`HAND_PITCH` (10-bit) and `ty` = `HAND_Y`.
    - Pulse `draw_ack`; go to SLIDE.
  - If `draw_req`=1 and `draw_slot` ≥ `MAX_SLOTS`: pulse `draw_ack` and `draw_err`; stay in IDLE; pins unchanged.
- State SLIDE, on each `frame_start`, per axis independently:
  - If |target − cur| ≤ `STEP`: cur ← target.
  - Otherwise: cur ← cur ± `STEP`, toward the target.
  - Arithmetic is 10-bit unsigned. Compare before subtracting so the result never underflows.
  - When both axes equal their targets after an update, go to HOLD (or DONE when the hold is compiled out) in the next cycle.
- State HOLD:
  - Frame counter loads `HOLD_FRAMES`−1 on entry.
  - Decrements on each `frame_start`.
  - On a `frame_start` with count 0, go to DONE.
- State DONE:
  - Lasts exactly one cycle; pulses `draw_done`.
  - Next state IDLE; on the same edge, `x_pin`/`y_pin` ← deck position.
- `busy` = `sprite_en` = 1 in SLIDE, HOLD and DONE.
- `draw_req` is ignored outside IDLE; no ack is issued.
- The requester must drop `draw_req` after `draw_ack`. A `draw_req` still high on return to IDLE is accepted as a new request.
- Parameter constraint: `HAND_X0` + (`MAX_SLOTS`−1)·`HAND_PITCH` + 30 ≤ 639, and `HAND_Y` + 50 ≤ 479. The block does no runtime clamping beyond this.
- `x_cnt`/`y_cnt` are not inputs. Pixel ownership is decided in the renderer.

## Timing
- `draw_ack` asserts in the cycle after `draw_req` is sampled high in IDLE. It is registered.
- A `frame_start` in the same cycle as acceptance does not move the sprite. The first move happens on the next `frame_start` after SLIDE is entered.
- `x_pin`/`y_pin` update on the clock edge that samples `frame_start`, then hold for the whole frame.
- Frames from acceptance to arrival = max(⌈|dx|/`STEP`⌉, ⌈|dy|/`STEP`⌉). If the target equals the deck position, arrival takes one frame.
- `draw_done` asserts one cycle after the final HOLD `frame_start`.
- Reset mid-animation: on the next edge, all outputs return to reset values and any pending pulse is dropped.

## Configuration
- `CARD_ANIM_HOLD_EN` defined: HOLD state and frame counter are present, as described above.
- `CARD_ANIM_HOLD_EN` undefined:
  - HOLD state and its counter are removed.
  - SLIDE goes directly to DONE on the cycle after arrival.
  - `HOLD_FRAMES` is unused.

## Test plan
- Reset, then idle 10 cycles → `x_pin`=300, `y_pin`=200, `sprite_en`=0, `busy`=0, no pulses.
- Request `draw_slot`=2 with defaults → one `draw_ack`. After the 1st `frame_start`, pins are (292,208). Arrival at (112,400) on the 25th `frame_start`. `draw_done` one cycle after the 29th `frame_start` with hold; after the arrival cycle+1 without hold. Then pins are (300,200).
- Request `draw_slot`=7 → target x=292 (|dx|=8) is reached on the 1st frame; y takes 25 frames.
- `draw_slot`=5 with `MAX_SLOTS`=4 → `draw_ack` and `draw_err` pulse together; `busy` stays 0.
- `draw_req` held high during SLIDE → no second ack until IDLE. Then a second ack is issued the cycle after DONE→IDLE.
- `rst` asserted after 10 frames of SLIDE → next edge gives pins (300,200), `busy`=0, no `draw_done`.
